// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - multi-channel grey-code digit scanner with snapshot, hold, blanking and error flag
// Shows one channel's digits MSB first, then a DP marker, each for P_DWELL+1 clocks.

module scan_mux #(
  parameter int P_CHANNELS = 16,
  parameter int P_DIGITS   = 3,
  parameter int P_DWELL    = 20000,
  parameter int P_SEL_W    = 5
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [P_CHANNELS*P_DIGITS*5-1:0]   i_data,
  input  logic [P_SEL_W-1:0]                 i_sel,
  input  logic                               i_hold,
  input  logic                               i_lzb,
  output logic [4:0]                         o_code,
  output logic [$clog2(P_DIGITS+1)-1:0]      o_digit,
  output logic                               o_frame,
  output logic                               o_err
);

  localparam int DW = $clog2(P_DIGITS + 1);
  localparam int CW = (P_DWELL > 0) ? $clog2(P_DWELL + 1) : 1;
  localparam int SW = P_DIGITS * 5;

  localparam logic [CW-1:0] DWELL_MAX = CW'(P_DWELL);
  localparam logic [DW-1:0] LAST_POS  = DW'(P_DIGITS - 1);
  localparam logic [DW-1:0] DP_POS    = DW'(P_DIGITS);

  localparam logic [4:0] C_ZERO  = 5'b10001;
  localparam logic [4:0] C_ONE   = 5'b00001;
  localparam logic [4:0] C_TWO   = 5'b00011;
  localparam logic [4:0] C_THREE = 5'b00010;
  localparam logic [4:0] C_FOUR  = 5'b00110;
  localparam logic [4:0] C_FIVE  = 5'b00100;
  localparam logic [4:0] C_SIX   = 5'b01100;
  localparam logic [4:0] C_SEVEN = 5'b01000;
  localparam logic [4:0] C_EIGHT = 5'b11000;
  localparam logic [4:0] C_NINE  = 5'b10000;
  localparam logic [4:0] C_DP    = 5'b10101;
  localparam logic [4:0] C_BLANK = 5'b00000;

  typedef enum logic [1:0] {S_START, S_DIG, S_DP} state_t;

  function automatic logic [4:0] code_of(input int d);
    case (d)
      0:       return C_ZERO;
      1:       return C_ONE;
      2:       return C_TWO;
      3:       return C_THREE;
      4:       return C_FOUR;
      5:       return C_FIVE;
      6:       return C_SIX;
      7:       return C_SEVEN;
      8:       return C_EIGHT;
      9:       return C_NINE;
      default: return C_BLANK;
    endcase
  endfunction

  function automatic logic is_digit(input logic [4:0] c);
    case (c)
      C_ZERO, C_ONE, C_TWO, C_THREE, C_FOUR,
      C_FIVE, C_SIX, C_SEVEN, C_EIGHT, C_NINE: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Leading-zero blanking looks at digits 0..k; the last digit always shows.
  function automatic logic [4:0] disp(input logic [SW-1:0] s, input int k, input logic lzb);
    logic       lead;
    logic [4:0] c;
    lead = 1'b1;
    for (int j = 0; j < P_DIGITS; j++)
      if (j <= k && s[j*5 +: 5] != C_ZERO) lead = 1'b0;
    c = s[k*5 +: 5];
    if (!is_digit(c)) return C_BLANK;
    if (lzb && k < P_DIGITS - 1 && lead) return C_BLANK;
    return c;
  endfunction

  logic [7:0]    rst_sr;
  logic          int_rst;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] snap, snap_nx, chan, errpat;
  logic [4:0]    code_nx;
  logic [DW-1:0] digit_nx;
  logic          frame_nx, err_nx, tick, sel_ok, bad;

  assign int_rst = rst_sr[7];
  assign tick    = (cnt == DWELL_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sr <= '1;
    else          rst_sr <= {rst_sr[6:0], 1'b0};
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = tick ? '0 : cnt + CW'(1);
    snap_nx  = snap;
    code_nx  = o_code;
    digit_nx = o_digit;
    frame_nx = 1'b0;
    err_nx   = o_err;
    chan     = '0;
    sel_ok   = 1'b0;
    bad      = 1'b0;
    errpat   = '0;
    for (int c = 0; c < P_CHANNELS; c++) begin
      if (i_sel == P_SEL_W'(c)) begin
        chan   = i_data[c*SW +: SW];
        sel_ok = 1'b1;
      end
    end
    for (int k = 0; k < P_DIGITS; k++) errpat[k*5 +: 5] = code_of((4 + k) % 10);

    if (tick) begin
      case (state)
        S_START, S_DP: begin
          if (state == S_START || !i_hold) begin
            snap_nx = sel_ok ? chan : errpat;
            for (int k = 0; k < P_DIGITS; k++)
              if (!is_digit(snap_nx[k*5 +: 5])) bad = 1'b1;
            err_nx = bad;
          end
          state_nx = S_DIG;
          digit_nx = '0;
          code_nx  = disp(snap_nx, 0, i_lzb);
        end
        S_DIG: begin
          if (o_digit == LAST_POS) begin
            state_nx = S_DP;
            digit_nx = DP_POS;
            code_nx  = C_DP;
            frame_nx = 1'b1;
          end else begin
            digit_nx = o_digit + DW'(1);
            code_nx  = disp(snap_nx, int'(o_digit) + 1, i_lzb);
          end
        end
        default: state_nx = S_START;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_START;
      cnt     <= '0;
      snap    <= '0;
      o_code  <= C_BLANK;
      o_digit <= '0;
      o_frame <= 1'b0;
      o_err   <= 1'b0;
    end else if (int_rst) begin
      state   <= S_START;
      cnt     <= '0;
      snap    <= '0;
      o_code  <= C_BLANK;
      o_digit <= '0;
      o_frame <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      snap    <= snap_nx;
      o_code  <= code_nx;
      o_digit <= digit_nx;
      o_frame <= frame_nx;
      o_err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed bench for scan_mux with 4 channels, 3 digits, dwell 3
// Frames are checked position by position against hand-written code tables.

module tb_scan_mux;

  localparam logic [4:0] ZERO  = 5'b10001;
  localparam logic [4:0] ONE   = 5'b00001;
  localparam logic [4:0] TWO   = 5'b00011;
  localparam logic [4:0] THREE = 5'b00010;
  localparam logic [4:0] FIVE  = 5'b00100;
  localparam logic [4:0] SIX   = 5'b01100;
  localparam logic [4:0] SEVEN = 5'b01000;
  localparam logic [4:0] EIGHT = 5'b11000;
  localparam logic [4:0] NINE  = 5'b10000;
  localparam logic [4:0] DP    = 5'b10101;
  localparam logic [4:0] BLANK = 5'b00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [59:0] data = '0;
  logic [2:0]  sel = 3'd0;
  logic        hold = 1'b0;
  logic        lzb = 1'b0;
  logic [4:0]  code;
  logic [1:0]  digit;
  logic        frame;
  logic        err;

  int checks = 0;
  int failures = 0;

  scan_mux #(.P_CHANNELS(4), .P_DIGITS(3), .P_DWELL(3), .P_SEL_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_sel(sel),
    .i_hold(hold), .i_lzb(lzb), .o_code(code), .o_digit(digit),
    .o_frame(frame), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ch(input int c, input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2);
    data[(c*3+0)*5 +: 5] = d0;
    data[(c*3+1)*5 +: 5] = d1;
    data[(c*3+2)*5 +: 5] = d2;
  endtask

  // Leaves the bench #1 after an edge with the next edge being the first D0 tick.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code", 32'(code), 32'(BLANK));
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 11; e++) begin
      @(posedge clk);
      #1;
      check("rst_hold_code", 32'(code), 32'(BLANK));
      check("rst_hold_frame", 32'(frame), 32'd0);
    end
  endtask

  // One full frame of 16 clocks starting at the D0 tick.
  task automatic expect_frame(input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] c2,
                              input logic exp_err, input string tag);
    logic [4:0] exp;
    for (int p = 0; p < 4; p++) begin
      exp = (p == 0) ? c0 : (p == 1) ? c1 : (p == 2) ? c2 : DP;
      for (int e = 0; e < 4; e++) begin
        @(posedge clk);
        #1;
        check({tag, "_code"}, 32'(code), 32'(exp));
        if (e == 0) begin
          check({tag, "_digit"}, 32'(digit), 32'(p));
          check({tag, "_err"}, 32'(err), 32'(exp_err));
        end
        if (e < 2) check({tag, "_frame"}, 32'(frame), 32'(p == 3 && e == 0));
      end
    end
  endtask

  initial begin
    set_ch(2, TWO, ZERO, SEVEN);
    sel = 3'd2;
    #2;
    do_reset();
    expect_frame(TWO, ZERO, SEVEN, 1'b0, "ch2_a");
    expect_frame(TWO, ZERO, SEVEN, 1'b0, "ch2_b");

    sel = 3'd7;
    expect_frame(5'b00110, FIVE, SIX, 1'b0, "oor");

    set_ch(0, ZERO, ZERO, ZERO);
    sel = 3'd0;
    lzb = 1'b1;
    expect_frame(BLANK, BLANK, ZERO, 1'b0, "lzb_on");
    lzb = 1'b0;
    expect_frame(ZERO, ZERO, ZERO, 1'b0, "lzb_off");

    set_ch(1, ONE, TWO, THREE);
    sel = 3'd1;
    expect_frame(ONE, TWO, THREE, 1'b0, "pre_hold");
    hold = 1'b1;
    fork
      expect_frame(ONE, TWO, THREE, 1'b0, "hold_a");
      begin
        repeat (6) @(posedge clk);
        #2;
        set_ch(1, NINE, EIGHT, SIX);
        sel = 3'd2;
      end
    join
    fork
      expect_frame(ONE, TWO, THREE, 1'b0, "hold_b");
      begin
        repeat (6) @(posedge clk);
        #2;
        sel = 3'd1;
      end
    join
    hold = 1'b0;
    expect_frame(NINE, EIGHT, SIX, 1'b0, "hold_rel");

    set_ch(3, FIVE, 5'b11111, ONE);
    sel = 3'd3;
    expect_frame(FIVE, BLANK, ONE, 1'b1, "bad");
    set_ch(3, FIVE, SEVEN, ONE);
    expect_frame(FIVE, SEVEN, ONE, 1'b0, "fixed");

    set_ch(3, FIVE, 5'b11111, ONE);
    repeat (6) @(posedge clk);
    #1;
    check("mid_d1_code", 32'(code), 32'(BLANK));
    check("mid_d1_digit", 32'(digit), 32'd1);
    check("mid_d1_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_code", 32'(code), 32'(BLANK));
    check("async_digit", 32'(digit), 32'd0);
    check("async_frame", 32'(frame), 32'd0);
    check("async_err", 32'(err), 32'd0);
    do_reset();
    expect_frame(FIVE, BLANK, ONE, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
